// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, state enum,
// ALU operation and ALU B-operand select codes.
package ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_HALT     = 4'd12
  } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier; exactly one output is high for any input.
module opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] op_code,
  output logic       r_format,
  output logic       addi,
  output logic       lw,
  output logic       sw,
  output logic       beq,
  output logic       bne,
  output logic       bgtz,
  output logic       illegal
);

  always_comb begin
    r_format = 1'b0;
    addi     = 1'b0;
    lw       = 1'b0;
    sw       = 1'b0;
    beq      = 1'b0;
    bne      = 1'b0;
    bgtz     = 1'b0;
    illegal  = 1'b0;
    case (op_code)
      OP_R:    r_format = 1'b1;
      OP_ADDI: addi     = 1'b1;
      OP_LW:   lw       = 1'b1;
      OP_SW:   sw       = 1'b1;
      OP_BEQ:  beq      = 1'b1;
      OP_BNE:  bne      = 1'b1;
      OP_BGTZ: bgtz     = 1'b1;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle datapath sequencer: fetch/decode/execute/memory/writeback with
// a mem_ready wait handshake on the unified memory.
module multicycle_control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_code,
  input  logic       mem_ready,
  input  logic       alu_zero,
  input  logic       alu_gtz,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_source,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;

  logic in_r, in_addi, in_lw, in_sw, in_beq, in_bne, in_bgtz, in_ill;
  logic q_r, q_addi, q_lw, q_sw, q_beq, q_bne, q_bgtz, q_ill;
  logic dec_q_unused;

  opcode_decoder u_dec_in (
    .op_code (op_code),
    .r_format(in_r),
    .addi    (in_addi),
    .lw      (in_lw),
    .sw      (in_sw),
    .beq     (in_beq),
    .bne     (in_bne),
    .bgtz    (in_bgtz),
    .illegal (in_ill)
  );

  // Latched opcode drives the post-decode choices (lw vs sw, branch flavour).
  opcode_decoder u_dec_q (
    .op_code (op_q),
    .r_format(q_r),
    .addi    (q_addi),
    .lw      (q_lw),
    .sw      (q_sw),
    .beq     (q_beq),
    .bne     (q_bne),
    .bgtz    (q_bgtz),
    .illegal (q_ill)
  );

  assign dec_q_unused = ^{q_r, q_addi, q_sw, q_ill};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = op_code;
        if (in_lw || in_sw)                  state_d = S_MEM_ADDR;
        else if (in_r)                       state_d = S_EXEC_R;
        else if (in_addi)                    state_d = S_EXEC_I;
        else if (in_beq || in_bne || in_bgtz) state_d = S_BRANCH;
        else if (in_ill) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_MEM_ADDR: state_d = q_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore decode of the state; only the handshake/flag-qualified strobes look at inputs.
  always_comb begin
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    pc_source  = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_4;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR, S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = 1'b1;
        pc_write   = (q_beq & alu_zero) | (q_bne & ~alu_zero) | (q_bgtz & alu_gtz);
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: instruction-level generator expands each instruction into
// per-cycle inputs and expected control vectors; a negedge monitor compares.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op_code = 6'd0;
  logic       mem_ready = 1'b0, alu_zero = 1'b0, alu_gtz = 1'b0;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, pc_source, instr_done, illegal;
  logic [1:0] alu_src_b, alu_op;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op_code(op_code), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .alu_gtz(alu_gtz), .pc_write(pc_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, rdy, z, g;
    logic [5:0] op;
    logic [15:0] exp;
  } cyc_t;

  cyc_t        plan[$];
  logic [15:0] exp_q[$];
  logic [5:0]  cur_op;
  logic        ill_m;
  int          errors = 0, checks = 0, cyc_n = 0;

  // Vector order: pcw iord mrd mwr irw rdst m2r rw asa asb[2] aop[2] psrc done ill
  function automatic logic [15:0] mk(input logic pcw, iord, mrd, mwr, irw, rdst,
                                     m2r, rw, asa, input logic [1:0] asb, aop,
                                     input logic psrc, done, ill);
    return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc, done, ill};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic push(input logic rst, rdy, z, g, input logic [15:0] e);
    cyc_t c;
    c.rst = rst; c.rdy = rdy; c.z = z; c.g = g; c.op = cur_op; c.exp = e;
    plan.push_back(c);
  endtask

  task automatic gen_reset(input int n);
    ill_m = 1'b0;
    repeat (n) push(1'b1, rb(), rb(), rb(), 16'h0);
    push(1'b0, rb(), rb(), rb(), 16'h0);  // first cycle after release is idle
  endtask

  // wm: memory wait cycles, or number of halt cycles to observe for an illegal op.
  task automatic gen_instr(input logic [5:0] op, input int wf, wm,
                           input logic bz, bg, input bit abort_wr);
    logic tk;
    cur_op = op;
    repeat (wf) push(1'b0, 1'b0, rb(), rb(), mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,0,0,ill_m));
    push(1'b0, 1'b1, rb(), rb(), mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,0,0,ill_m));
    push(1'b0, rb(), rb(), rb(), mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0,ill_m));
    case (op)
      6'b000000: begin
        push(1'b0, rb(), rb(), rb(), mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,0,0,ill_m));
        push(1'b0, rb(), rb(), rb(), mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,0,1,ill_m));
      end
      6'b001000: begin
        push(1'b0, rb(), rb(), rb(), mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,ill_m));
        push(1'b0, rb(), rb(), rb(), mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,0,1,ill_m));
      end
      6'b100011: begin
        push(1'b0, rb(), rb(), rb(), mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,ill_m));
        repeat (wm) push(1'b0, 1'b0, rb(), rb(), mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,0,0,ill_m));
        push(1'b0, 1'b1, rb(), rb(), mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,0,0,ill_m));
        push(1'b0, rb(), rb(), rb(), mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,0,1,ill_m));
      end
      6'b101011: begin
        push(1'b0, rb(), rb(), rb(), mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,ill_m));
        if (abort_wr) begin
          push(1'b0, 1'b0, rb(), rb(), mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,0,0,ill_m));
        end else begin
          repeat (wm) push(1'b0, 1'b0, rb(), rb(), mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,0,0,ill_m));
          push(1'b0, 1'b1, rb(), rb(), mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,0,1,ill_m));
        end
      end
      6'b000100, 6'b000101, 6'b000111: begin
        tk = (op == 6'b000100) ? bz : (op == 6'b000101) ? ~bz : bg;
        push(1'b0, rb(), bz, bg, mk(tk,0,0,0,0,0,0,0,1,2'b00,2'b01,1,1,ill_m));
      end
      default: begin
        ill_m = 1'b1;
        repeat (wm) push(1'b0, rb(), rb(), rb(), mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,1));
      end
    endcase
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011,
                      6'b000100, 6'b000101, 6'b000111};
  endfunction

  // Monitor: every cycle the DUT presents a control vector; compare against the queue head.
  always @(negedge clk) begin
    logic [15:0] got, want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
              reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL ctrl cycle %0d op=%b: got=%b want=%b", cyc_n, op_code, got, want);
      end
    end
  end

  initial begin
    logic [5:0] ops[7] = '{6'b000000, 6'b001000, 6'b100011, 6'b101011,
                           6'b000100, 6'b000101, 6'b000111};
    logic [5:0] op;
    cyc_t c;
    ill_m  = 1'b0;
    cur_op = 6'd0;

    gen_reset(3);
    gen_instr(6'b000000, 0, 0, 0, 0, 0);
    gen_instr(6'b100011, 2, 3, 0, 0, 0);
    gen_instr(6'b101011, 0, 0, 0, 0, 0);
    gen_instr(6'b000100, 0, 0, 1, 0, 0);
    gen_instr(6'b000100, 0, 0, 0, 1, 0);
    gen_instr(6'b000101, 0, 0, 1, 0, 0);
    gen_instr(6'b000101, 1, 0, 0, 0, 0);
    gen_instr(6'b000111, 0, 0, 0, 1, 0);
    gen_instr(6'b000111, 0, 0, 1, 0, 0);
    gen_instr(6'b001000, 1, 0, 0, 0, 0);
    gen_instr(6'b111111, 0, 20, 0, 0, 0);
    gen_reset(2);
    gen_instr(6'b101011, 1, 0, 0, 0, 1);
    gen_reset(1);
    gen_instr(6'b000000, 0, 0, 0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(11, 0) == 0) begin
        do op = 6'($urandom); while (legal(op));
        gen_instr(op, $urandom_range(2, 0), $urandom_range(6, 1), 0, 0, 0);
        gen_reset($urandom_range(3, 1));
      end else begin
        op = ops[$urandom_range(6, 0)];
        gen_instr(op, $urandom_range(3, 0), $urandom_range(3, 0), rb(), rb(), 0);
      end
    end

    while (plan.size() > 0) begin
      @(posedge clk);
      #1;
      c = plan.pop_front();
      reset     = c.rst;
      mem_ready = c.rdy;
      alu_zero  = c.z;
      alu_gtz   = c.g;
      op_code   = c.op;
      cyc_n++;
      exp_q.push_back(c.exp);
    end
    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Sequencing controller for the multi-cycle variant of the processor datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath mux, register-enable and memory strobe from its state, and handles a ready/wait handshake with the unified instruction/data memory. It supports the same instruction set as the single-cycle core: R-format, addi, lw, sw, beq, bne and bgtz.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; one clock domain, no other clocks
- op_code  in  6  IR[31:26]; sampled in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- alu_zero  in  1  ALU result == 0
- alu_gtz  in  1  rs > 0 (signed), from the datapath comparator
- pc_write  out  1  PC register load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = A (rs)
- alu_src_b  out  2  00 = B (rt), 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_op  out  2  00 = add, 01 = subtract, 10 = decode funct
- pc_source  out  1  0 = ALU result, 1 = ALUOut (branch target)
- instr_done  out  1  one-cycle pulse in an instruction's final cycle
- illegal  out  1  sticky: unsupported opcode seen

## Operation
- Opcodes: R 000000, addi 001000, lw 100011, sw 101011, beq 000100, bne 000101, bgtz 000111. Anything else is illegal.
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, HALT.
- Opcode is latched into op_q on the DECODE→next transition. Branch type and writeback selects use op_q.
- Transitions:
  - IDLE→FETCH unconditionally.
  - FETCH→DECODE when mem_ready.
  - DECODE→MEM_ADDR (lw/sw), EXEC_R (R), EXEC_I (addi), BRANCH (beq/bne/bgtz), HALT (illegal).
  - MEM_ADDR→MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD→MEM_WB when mem_ready.
  - MEM_WR→FETCH when mem_ready.
  - EXEC_R→R_WB; EXEC_I→I_WB.
  - R_WB, I_WB, MEM_WB, BRANCH→FETCH.
  - HALT→HALT until reset.
- Outputs per state; any output not listed is 0:
  - IDLE, HALT: all 0.
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00. ir_write=pc_write=mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - MEM_ADDR, EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_RD: mem_read=1, i_or_d=1.
  - MEM_WR: mem_write=1, i_or_d=1.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
  - I_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=1. pc_write = (beq & alu_zero) | (bne & ~alu_zero) | (bgtz & alu_gtz).
- instr_done=1 in: MEM_WB, R_WB, I_WB, BRANCH, and in MEM_WR when mem_ready.
- illegal is set on DECODE→HALT and held until reset.

## Timing
- Reset: state=IDLE, op_q=0, illegal=0. All outputs 0 while reset is asserted and in the first cycle after release. FETCH is entered on the second edge after release.
- Outputs are Moore from the state register. The exceptions are ir_write/pc_write in FETCH, pc_write in BRANCH, and instr_done in MEM_WR, which are combinational on mem_ready or the flags.
- Cycles with zero wait states, FETCH to last state inclusive: branch 3, R/addi/sw 4, lw 5.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Strobes and i_or_d stay constant throughout the wait.
- mem_read and mem_write are never both 1.
- ir_write/pc_write pulse exactly once per fetch. reg_write pulses exactly once per writeback.
- Reset asserted mid-instruction forces IDLE immediately; no further strobes are issued.

## Structure
- Package ctrl_pkg holds: opcode localparams, the state enum (4-bit binary encoding), and the alu_op and alu_src_b encodings.
- One sub-module, opcode_decoder: combinational op_code → one-hot {r_format, addi, lw, sw, beq, bne, bgtz, illegal}. It is used in DECODE transition logic and on op_q for BRANCH.

## Test plan
- Reset release, mem_ready=1, op 000000: states IDLE,FETCH,DECODE,EXEC_R,R_WB. Expect alu_op=10 in EXEC_R; reg_write=1, reg_dst=1 in R_WB; instr_done in cycle 5.
- lw (100011) with mem_ready low 2 cycles in FETCH and 3 in MEM_RD: 10 cycles total. Expect mem_read held through waits; exactly one ir_write; reg_write with mem_to_reg=1 once.
- sw (101011), mem_ready=1: expect mem_write=1, i_or_d=1 one cycle and reg_write never 1.
- Branches: beq with alu_zero=1 → pc_write=1, pc_source=1; bne with alu_zero=1 → pc_write=0; bgtz with alu_gtz=1 → pc_write=1; bgtz with alu_gtz=0 → pc_write=0.
- op_code 111111 → HALT. Expect illegal=1 and all strobes 0 for 20 cycles; reset clears illegal.
- Assert reset while in MEM_WR with mem_ready=0: mem_write drops immediately and the FSM restarts at IDLE→FETCH.
